// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types for the I2C write arbiter
package i2c_arb_pkg;

    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        DATA,
        GAP
    } state_t;

    typedef struct packed {
        logic [I2C_BYTE_W-1:0] addr;
        logic [I2C_BYTE_W-1:0] data;
    } i2c_wr_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker
// Ports: req (request levels), ptr (last served index);
//        pick (one-hot winner), index (winner index), valid (any request).
// The search starts at ptr+1 and wraps, so the last owner has lowest priority.
module i2c_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      index,
    output logic               valid
);

    int cand;

    always_comb begin
        pick  = '0;
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[IW'(cand)]) begin
                valid           = 1'b1;
                index           = IW'(cand);
                pick[IW'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_arbiter.sv
// rtl/i2c_write_arbiter.sv - round-robin arbiter sharing one I2C master among register writers
// Optional: define I2C_ARB_TIMEOUT_EN to build the ADDR/DATA watchdog that drives err.
// Ports: clk, reset (async active-low); req/req_addr/req_data in per requester;
//        gnt/ack/err out per requester; busy; i2c_start/i2c_data to the master; i2c_done from it.
module i2c_write_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][I2C_BYTE_W-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][I2C_BYTE_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  ack,
    output logic [NUM_REQ-1:0]                  err,
    output logic                                busy,
    output logic                                i2c_start,
    output logic [I2C_BYTE_W-1:0]               i2c_data,
    input  logic                                i2c_done
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t                 state, state_nxt;
    logic [IW-1:0]          ptr, ptr_nxt;
    logic [IW-1:0]          owner, owner_nxt;
    i2c_wr_t                wr, wr_nxt;
    logic [GW-1:0]          gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0]     gnt_nxt, ack_nxt;
    logic                   start_nxt;
    logic [I2C_BYTE_W-1:0]  data_nxt;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;

    i2c_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick_oh),
        .index (pick_idx),
        .valid (pick_valid)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]      wd_cnt;
    logic [NUM_REQ-1:0] err_nxt;
    logic               timeout;

    // Counts consecutive byte-wait cycles; any i2c_done restarts the count.
    assign timeout = ((state == ADDR) || (state == DATA)) && !i2c_done
                     && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            err    <= '0;
        end else begin
            err <= err_nxt;
            if (((state == ADDR) || (state == DATA)) && !i2c_done && !timeout)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
        end
    end
`else
    assign err = '0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        wr_nxt    = wr;
        gap_nxt   = gap_cnt;
        gnt_nxt   = gnt;
        ack_nxt   = '0;
        start_nxt = 1'b0;
        data_nxt  = i2c_data;
`ifdef I2C_ARB_TIMEOUT_EN
        err_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt   = START;
                    owner_nxt   = pick_idx;
                    wr_nxt.addr = req_addr[pick_idx];
                    wr_nxt.data = req_data[pick_idx];
                    gnt_nxt     = pick_oh;
                    start_nxt   = 1'b1;
                    data_nxt    = req_addr[pick_idx];
                end
            end
            START: begin
                state_nxt = ADDR;
                data_nxt  = wr.addr;
            end
            ADDR: begin
                if (i2c_done) begin
                    state_nxt = DATA;
                    data_nxt  = wr.data;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (timeout) begin
                    err_nxt[owner] = 1'b1;
                    ptr_nxt        = owner;
                    state_nxt      = GAP;
                    gap_nxt        = GW'(GAP_CYCLES - 1);
                end
`endif
            end
            DATA: begin
                if (i2c_done) begin
                    ack_nxt[owner] = 1'b1;
                    ptr_nxt        = owner;
                    state_nxt      = GAP;
                    gap_nxt        = GW'(GAP_CYCLES - 1);
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (timeout) begin
                    err_nxt[owner] = 1'b1;
                    ptr_nxt        = owner;
                    state_nxt      = GAP;
                    gap_nxt        = GW'(GAP_CYCLES - 1);
                end
`endif
            end
            GAP: begin
                // gnt is kept through the ack/err cycle, dropped on the next one.
                gnt_nxt = '0;
                if (gap_cnt == '0)
                    state_nxt = IDLE;
                else
                    gap_nxt = gap_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ - 1);
            owner     <= '0;
            wr        <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            i2c_start <= 1'b0;
            i2c_data  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            wr        <= wr_nxt;
            gap_cnt   <= gap_nxt;
            gnt       <= gnt_nxt;
            ack       <= ack_nxt;
            busy      <= (state_nxt != IDLE);
            i2c_start <= start_nxt;
            i2c_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// tb/tb_i2c_write_arbiter.sv - directed self-checking bench for i2c_write_arbiter
module tb_i2c_write_arbiter;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0][7:0]  req_addr;
    logic [1:0][7:0]  req_data;
    logic [1:0]       gnt;
    logic [1:0]       ack;
    logic [1:0]       err;
    logic             busy;
    logic             i2c_start;
    logic [7:0]       i2c_data;
    logic             i2c_done;

    int n_pass  = 0;
    int n_total = 0;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int LAT = 40;
`else
    localparam int LAT = 200;
`endif

    i2c_write_arbiter #(
        .NUM_REQ        (2),
        .GAP_CYCLES     (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .gnt       (gnt),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every step lands 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic master_done(input int lat);
        tick(lat - 1);
        i2c_done = 1'b1;
        tick(1);
        i2c_done = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!i2c_start && cyc < 200);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 200) begin
            tick(1);
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        n_total++; if (gnt !== 2'b00) $display("FAIL rst_gnt got %b want 00", gnt); else n_pass++;
        n_total++; if (ack !== 2'b00) $display("FAIL rst_ack got %b want 00", ack); else n_pass++;
        n_total++; if (err !== 2'b00) $display("FAIL rst_err got %b want 00", err); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_total++; if (i2c_start !== 1'b0) $display("FAIL rst_start got %b want 0", i2c_start); else n_pass++;
        n_total++; if (i2c_data !== 8'h00) $display("FAIL rst_data got %h want 00", i2c_data); else n_pass++;
        reset = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        req         = 2'b01;
        req_addr[0] = 8'h12;
        req_data[0] = 8'h80;
        tick(1);
        n_total++; if (i2c_start !== 1'b1) $display("FAIL t1_start got %b want 1", i2c_start); else n_pass++;
        n_total++; if (i2c_data !== 8'h12) $display("FAIL t1_addr got %h want 12", i2c_data); else n_pass++;
        n_total++; if (gnt !== 2'b01) $display("FAIL t1_gnt got %b want 01", gnt); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL t1_busy got %b want 1", busy); else n_pass++;
        tick(1);
        n_total++; if (i2c_start !== 1'b0) $display("FAIL t1_start_len got %b want 0", i2c_start); else n_pass++;
        master_done(LAT);
        n_total++; if (i2c_data !== 8'h80) $display("FAIL t1_data got %h want 80", i2c_data); else n_pass++;
        n_total++; if (ack !== 2'b00) $display("FAIL t1_early_ack got %b want 00", ack); else n_pass++;
        master_done(LAT);
        n_total++; if (ack !== 2'b01) $display("FAIL t1_ack got %b want 01", ack); else n_pass++;
        n_total++; if (gnt !== 2'b01) $display("FAIL t1_gnt_at_ack got %b want 01", gnt); else n_pass++;
        req = 2'b00;
        tick(1);
        n_total++; if (ack !== 2'b00) $display("FAIL t1_ack_len got %b want 00", ack); else n_pass++;
        n_total++; if (gnt !== 2'b00) $display("FAIL t1_gnt_clr got %b want 00", gnt); else n_pass++;
        tick(14);
        n_total++; if (busy !== 1'b1) $display("FAIL t1_gap_busy got %b want 1", busy); else n_pass++;
        tick(1);
        n_total++; if (busy !== 1'b0) $display("FAIL t1_gap_end got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        int         cyc;
        int         n_ack0;
        int         n_ack1;
        logic [1:0] exp_g;
        logic [7:0] exp_a;
        logic [7:0] exp_d;
        n_ack0 = 0;
        n_ack1 = 0;
        reset       = 1'b0;
        req         = 2'b11;
        req_addr[0] = 8'hA0;
        req_data[0] = 8'hC0;
        req_addr[1] = 8'hB1;
        req_data[1] = 8'hD1;
        tick(2);
        reset = 1'b1;
        for (int w = 0; w < 10; w++) begin
            exp_g = (w % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (w % 2 == 0) ? 8'hA0 : 8'hB1;
            exp_d = (w % 2 == 0) ? 8'hC0 : 8'hD1;
            wait_start(cyc);
            n_total++; if (i2c_start !== 1'b1) $display("FAIL t2_start w%0d timed out after %0d cycles", w, cyc); else n_pass++;
            n_total++; if (gnt !== exp_g) $display("FAIL t2_gnt w%0d got %b want %b", w, gnt, exp_g); else n_pass++;
            n_total++; if (i2c_data !== exp_a) $display("FAIL t2_addr w%0d got %h want %h", w, i2c_data, exp_a); else n_pass++;
            tick(1);
            master_done(LAT);
            n_total++; if (i2c_data !== exp_d) $display("FAIL t2_data w%0d got %h want %h", w, i2c_data, exp_d); else n_pass++;
            master_done(LAT);
            n_total++; if (ack !== exp_g) $display("FAIL t2_ack w%0d got %b want %b", w, ack, exp_g); else n_pass++;
            n_total++; if (err !== 2'b00) $display("FAIL t2_err w%0d got %b want 00", w, err); else n_pass++;
            if (ack[0]) n_ack0++;
            if (ack[1]) n_ack1++;
        end
        n_total++; if (n_ack0 != 5 || n_ack1 != 5) $display("FAIL t2_balance got %0d/%0d want 5/5", n_ack0, n_ack1); else n_pass++;
        req = 2'b00;
        wait_idle();
        n_total++; if (busy !== 1'b0) $display("FAIL t2_idle got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_latch_hold();
        int cyc;
        req         = 2'b10;
        req_addr[1] = 8'h3C;
        req_data[1] = 8'h5A;
        wait_start(cyc);
        n_total++; if (gnt !== 2'b10) $display("FAIL t3_gnt got %b want 10", gnt); else n_pass++;
        tick(1);
        req         = 2'b00;
        req_addr[1] = 8'hFF;
        req_data[1] = 8'hEE;
        n_total++; if (i2c_data !== 8'h3C) $display("FAIL t3_addr got %h want 3c", i2c_data); else n_pass++;
        master_done(LAT);
        n_total++; if (i2c_data !== 8'h5A) $display("FAIL t3_data got %h want 5a", i2c_data); else n_pass++;
        master_done(LAT);
        n_total++; if (ack !== 2'b10) $display("FAIL t3_ack got %b want 10", ack); else n_pass++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int cyc;
        req         = 2'b01;
        req_addr[0] = 8'h44;
        req_data[0] = 8'h55;
        wait_start(cyc);
        tick(1);
        master_done(LAT);
        tick(3);
        reset = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || gnt !== 2'b00) $display("FAIL t4_async got busy %b gnt %b want 0 00", busy, gnt); else n_pass++;
        tick(1);
        n_total++; if (i2c_data !== 8'h00) $display("FAIL t4_data got %h want 00", i2c_data); else n_pass++;
        n_total++; if (ack !== 2'b00 || i2c_start !== 1'b0) $display("FAIL t4_outs got ack %b start %b want 00 0", ack, i2c_start); else n_pass++;
        reset = 1'b1;
        wait_start(cyc);
        n_total++; if (cyc != 1) $display("FAIL t4_restart got %0d cycles want 1", cyc); else n_pass++;
        n_total++; if (i2c_data !== 8'h44) $display("FAIL t4_addr got %h want 44", i2c_data); else n_pass++;
        tick(1);
        master_done(LAT);
        master_done(LAT);
        n_total++; if (ack !== 2'b01) $display("FAIL t4_ack got %b want 01", ack); else n_pass++;
        req = 2'b00;
        wait_idle();
    endtask

    task automatic test_stray_done();
        int cyc;
        i2c_done = 1'b1;
        tick(1);
        i2c_done = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL t5_idle_busy got %b want 0", busy); else n_pass++;
        n_total++; if (i2c_data !== 8'h55) $display("FAIL t5_idle_data got %h want 55", i2c_data); else n_pass++;
        n_total++; if (ack !== 2'b00) $display("FAIL t5_idle_ack got %b want 00", ack); else n_pass++;
        req         = 2'b10;
        req_addr[1] = 8'h66;
        req_data[1] = 8'h77;
        wait_start(cyc);
        tick(1);
        master_done(LAT);
        master_done(LAT);
        n_total++; if (ack !== 2'b10) $display("FAIL t5_ack got %b want 10", ack); else n_pass++;
        req = 2'b00;
        tick(2);
        i2c_done = 1'b1;
        tick(1);
        i2c_done = 1'b0;
        n_total++; if (ack !== 2'b00) $display("FAIL t5_gap_ack got %b want 00", ack); else n_pass++;
        n_total++; if (i2c_data !== 8'h77) $display("FAIL t5_gap_data got %h want 77", i2c_data); else n_pass++;
        tick(12);
        n_total++; if (busy !== 1'b1) $display("FAIL t5_gap_busy got %b want 1", busy); else n_pass++;
        tick(1);
        n_total++; if (busy !== 1'b0) $display("FAIL t5_gap_end got %b want 0", busy); else n_pass++;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        req = 2'b11;
        wait_start(cyc);
        n_total++; if (gnt !== 2'b01) $display("FAIL t6_gnt0 got %b want 01", gnt); else n_pass++;
        tick(1);
        tick(63);
        n_total++; if (err !== 2'b00) $display("FAIL t6_err_early got %b want 00", err); else n_pass++;
        tick(1);
        n_total++; if (err !== 2'b01) $display("FAIL t6_err got %b want 01", err); else n_pass++;
        n_total++; if (ack !== 2'b00) $display("FAIL t6_ack got %b want 00", ack); else n_pass++;
        wait_start(cyc);
        n_total++; if (gnt !== 2'b10) $display("FAIL t6_gnt1 got %b want 10", gnt); else n_pass++;
        req = 2'b00;
        tick(1);
        master_done(20);
        master_done(20);
        n_total++; if (ack !== 2'b10) $display("FAIL t6_ack1 got %b want 10", ack); else n_pass++;
        wait_idle();
    endtask
`endif

    initial begin
        reset       = 1'b0;
        req         = 2'b00;
        req_addr    = '0;
        req_data    = '0;
        i2c_done    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_latch_hold();
        test_reset_mid();
        test_stray_done();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
